// File: rtl/misere_board_ctrl.sv
// -----------------------------------------------------------------------------
// misere_board_ctrl
//
// Move controller for a misere N-in-a-row game on an N x N board. Completing a
// run of K identical symbols through the placed cell makes the mover lose.
// Either player may place either symbol.
//
// Each accepted command walks IDLE -> CHECK -> WRITE -> SCAN -> IDLE.
// CHECK rejects illegal moves. SCAN walks the four line directions one cell
// per cycle, so a legal move always takes the same number of cycles.
//
// Ports
//   clock       single clock, rising edge
//   reset       synchronous, active-high
//   cmd_valid   move command valid
//   cmd_ready   high only in IDLE
//   cmd_row     target row (zero-based)
//   cmd_col     target column (zero-based)
//   cmd_sym     symbol to place: 01 = X, 10 = O
//   rd_row      display read row address
//   rd_col      display read column address
//   rd_sym      cell contents at the read address, combinational;
//               00 when the address is off-board
//   turn        player to move: 01 = P1, 10 = P2
//   winner      00 none, 01 P1, 10 P2, 11 tie
//   game_over   sticky until reset
//   move_done   one-cycle pulse when a legal move completes
//   reject_err  one-cycle pulse when a command is rejected
//   move_count  number of legal moves played
// -----------------------------------------------------------------------------
module misere_board_ctrl #(
  parameter int N = 3,
  parameter int K = 3,
  localparam int RW = ($clog2(N) < 1) ? 1 : $clog2(N),
  localparam int CW = $clog2(N*N+1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [RW-1:0] cmd_row,
  input  logic [RW-1:0] cmd_col,
  input  logic [1:0]    cmd_sym,
  input  logic [RW-1:0] rd_row,
  input  logic [RW-1:0] rd_col,
  output logic [1:0]    rd_sym,
  output logic [1:0]    turn,
  output logic [1:0]    winner,
  output logic          game_over,
  output logic          move_done,
  output logic          reject_err,
  output logic [CW-1:0] move_count
);

  // Offset counter holds 1..K-1; the run counter holds up to 2*(K-1).
  localparam int OW = $clog2(K);
  localparam int NW = $clog2(2*K);
  localparam int IW = $clog2(2*N*N);

  typedef enum logic [1:0] {IDLE, CHECK, WRITE, SCAN} state_t;

  state_t state_reg, state_next;

  // The board is a flat vector of 2-bit cells in row-major order.
  logic [2*N*N-1:0] board_reg;

  logic [RW-1:0] row_reg, col_reg;
  logic [1:0]    sym_reg;

  // Scan position: direction, half (0 = plus side, 1 = minus side), offset.
  logic [1:0]    dir_reg;
  logic          half_reg;
  logic [OW-1:0] off_reg;
  logic [NW-1:0] run_cnt_reg;   // matches counted so far in this direction
  logic          alive_reg;     // current half-direction run still unbroken
  logic          loss_reg;      // an earlier direction already reached K

  logic [1:0]    turn_reg, winner_reg;
  logic          game_over_reg, move_done_reg, reject_err_reg;
  logic [CW-1:0] move_count_reg;

  function automatic logic [IW-1:0] cell_bit(input int r, input int c);
    return IW'(2 * (r * N + c));
  endfunction

  // ---------------------------------------------------------------------------
  // Display read port
  // ---------------------------------------------------------------------------
  logic          rd_in_range;
  logic [IW-1:0] rd_bit;

  assign rd_in_range = (int'(rd_row) < N) && (int'(rd_col) < N);
  assign rd_bit      = cell_bit(int'(rd_row), int'(rd_col));
  assign rd_sym      = rd_in_range ? board_reg[rd_bit +: 2] : 2'b00;

  // ---------------------------------------------------------------------------
  // Legality check on the registered command
  // ---------------------------------------------------------------------------
  logic          tgt_in_range, tgt_occupied, sym_ok, check_bad;
  logic [IW-1:0] tgt_bit;

  assign tgt_in_range = (int'(row_reg) < N) && (int'(col_reg) < N);
  assign tgt_bit      = cell_bit(int'(row_reg), int'(col_reg));
  // The cell is looked at only when it is on the board.
  assign tgt_occupied = tgt_in_range && (board_reg[tgt_bit +: 2] != 2'b00);
  assign sym_ok       = (sym_reg == 2'b01) || (sym_reg == 2'b10);
  assign check_bad    = game_over_reg || !tgt_in_range || tgt_occupied || !sym_ok;

  // ---------------------------------------------------------------------------
  // Scan probe: the cell at the current offset along the current direction
  // ---------------------------------------------------------------------------
  int            step_r, step_c, offset, probe_r, probe_c;
  logic          probe_in, probe_hit, off_last, dir_end, scan_last, dir_loss, lose_now;
  logic [1:0]    probe_cell;
  logic [NW-1:0] run_cnt_next;

  always_comb begin
    step_r = 0;
    step_c = 1;
    case (dir_reg)
      2'd0:    begin step_r = 0; step_c = 1;  end  // horizontal
      2'd1:    begin step_r = 1; step_c = 0;  end  // vertical
      2'd2:    begin step_r = 1; step_c = 1;  end  // main diagonal
      default: begin step_r = 1; step_c = -1; end  // anti-diagonal
    endcase
    offset     = half_reg ? -int'(off_reg) : int'(off_reg);
    probe_r    = int'(row_reg) + offset * step_r;
    probe_c    = int'(col_reg) + offset * step_c;
    probe_in   = (probe_r >= 0) && (probe_r < N) && (probe_c >= 0) && (probe_c < N);
    probe_cell = probe_in ? board_reg[cell_bit(probe_r, probe_c) +: 2] : 2'b00;
  end

  // Once a half-direction run breaks, the remaining cells of that half are
  // still visited (for fixed latency) but no longer counted.
  assign probe_hit    = alive_reg && probe_in && (probe_cell == sym_reg);
  assign run_cnt_next = run_cnt_reg + NW'(probe_hit);
  assign off_last     = (int'(off_reg) == K - 1);
  assign dir_end      = off_last && half_reg;
  assign scan_last    = dir_end && (dir_reg == 2'd3);
  assign dir_loss     = dir_end && (int'(run_cnt_next) + 1 >= K);
  assign lose_now     = loss_reg || dir_loss;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = CHECK;
      end
      CHECK:   state_next = check_bad ? IDLE : WRITE;
      WRITE:   state_next = SCAN;
      SCAN:    if (scan_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      board_reg      <= '0;
      row_reg        <= '0;
      col_reg        <= '0;
      sym_reg        <= 2'b00;
      dir_reg        <= 2'd0;
      half_reg       <= 1'b0;
      off_reg        <= '0;
      run_cnt_reg    <= '0;
      alive_reg      <= 1'b0;
      loss_reg       <= 1'b0;
      turn_reg       <= 2'b01;
      winner_reg     <= 2'b00;
      game_over_reg  <= 1'b0;
      move_count_reg <= '0;
      move_done_reg  <= 1'b0;
      reject_err_reg <= 1'b0;
    end else begin
      move_done_reg  <= 1'b0;
      reject_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            row_reg <= cmd_row;
            col_reg <= cmd_col;
            sym_reg <= cmd_sym;
          end
        end
        CHECK: begin
          if (check_bad) reject_err_reg <= 1'b1;
        end
        WRITE: begin
          board_reg[tgt_bit +: 2] <= sym_reg;
          dir_reg     <= 2'd0;
          half_reg    <= 1'b0;
          off_reg     <= OW'(1);
          run_cnt_reg <= '0;
          alive_reg   <= 1'b1;
          loss_reg    <= 1'b0;
        end
        SCAN: begin
          loss_reg <= lose_now;
          if (off_last) begin
            off_reg   <= OW'(1);
            alive_reg <= 1'b1;
            if (half_reg) begin
              half_reg    <= 1'b0;
              dir_reg     <= dir_reg + 2'd1;
              run_cnt_reg <= '0;
            end else begin
              half_reg    <= 1'b1;
              run_cnt_reg <= run_cnt_next;
            end
          end else begin
            off_reg     <= off_reg + OW'(1);
            alive_reg   <= probe_hit;
            run_cnt_reg <= run_cnt_next;
          end

          if (scan_last) begin
            move_done_reg  <= 1'b1;
            move_count_reg <= move_count_reg + CW'(1);
            if (lose_now) begin
              // The mover loses; turn stays on the mover.
              winner_reg    <= (turn_reg == 2'b01) ? 2'b10 : 2'b01;
              game_over_reg <= 1'b1;
            end else if (int'(move_count_reg) + 1 == N * N) begin
              winner_reg    <= 2'b11;
              game_over_reg <= 1'b1;
            end else begin
              turn_reg <= ~turn_reg;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign turn       = turn_reg;
  assign winner     = winner_reg;
  assign game_over  = game_over_reg;
  assign move_done  = move_done_reg;
  assign reject_err = reject_err_reg;
  assign move_count = move_count_reg;

endmodule

// File: tb/tb_misere_board_ctrl.sv
// -----------------------------------------------------------------------------
// tb_misere_board_ctrl
//
// Two instances: A uses N=3, K=3 and B uses N=5, K=4. Directed scenarios and
// random games on A are checked against a small game model. The model applies
// the rules directly: it walks each line until the run breaks.
// -----------------------------------------------------------------------------
module tb_misere_board_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: N=3, K=3
  logic       reset_a, a_valid, a_ready;
  logic [1:0] a_row, a_col, a_sym, a_rd_row, a_rd_col, a_rd_sym, a_turn, a_winner;
  logic       a_game_over, a_move_done, a_reject_err;
  logic [3:0] a_move_count;

  // Instance B: N=5, K=4
  logic       reset_b, b_valid, b_ready;
  logic [2:0] b_row, b_col, b_rd_row, b_rd_col;
  logic [1:0] b_sym, b_rd_sym, b_turn, b_winner;
  logic       b_game_over, b_move_done, b_reject_err;
  logic [4:0] b_move_count;

  misere_board_ctrl #(.N(3), .K(3)) dut_a (
    .clock(clk), .reset(reset_a), .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_row(a_row), .cmd_col(a_col), .cmd_sym(a_sym),
    .rd_row(a_rd_row), .rd_col(a_rd_col), .rd_sym(a_rd_sym),
    .turn(a_turn), .winner(a_winner), .game_over(a_game_over),
    .move_done(a_move_done), .reject_err(a_reject_err), .move_count(a_move_count)
  );

  misere_board_ctrl #(.N(5), .K(4)) dut_b (
    .clock(clk), .reset(reset_b), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_row(b_row), .cmd_col(b_col), .cmd_sym(b_sym),
    .rd_row(b_rd_row), .rd_col(b_rd_col), .rd_sym(b_rd_sym),
    .turn(b_turn), .winner(b_winner), .game_over(b_game_over),
    .move_done(b_move_done), .reject_err(b_reject_err), .move_count(b_move_count)
  );

  // ---------------------------------------------------------------------------
  // Reference game model for the 3x3, K=3 instance
  // ---------------------------------------------------------------------------
  localparam int MN = 3;
  localparam int MK = 3;
  int mb[MN][MN];
  int mturn, mwin, mcount;
  bit mover;

  task automatic model_reset();
    for (int r = 0; r < MN; r++)
      for (int c = 0; c < MN; c++)
        mb[r][c] = 0;
    mturn = 1; mwin = 0; mcount = 0; mover = 0;
  endtask

  function automatic int run_len(int r, int c, int dr, int dc, int s);
    int len = 0;
    int rr = r + dr;
    int cc = c + dc;
    while (rr >= 0 && rr < MN && cc >= 0 && cc < MN && mb[rr][cc] == s) begin
      len++;
      rr += dr;
      cc += dc;
    end
    return len;
  endfunction

  task automatic model_move(input int r, input int c, input int s, output bit rej);
    bit lost = 0;
    int dr, dc;
    rej = mover || r < 0 || r >= MN || c < 0 || c >= MN || !(s == 1 || s == 2);
    if (!rej) rej = (mb[r][c] != 0);
    if (rej) return;
    mb[r][c] = s;
    mcount++;
    for (int d = 0; d < 4; d++) begin
      case (d)
        0: begin dr = 0; dc = 1;  end
        1: begin dr = 1; dc = 0;  end
        2: begin dr = 1; dc = 1;  end
        default: begin dr = 1; dc = -1; end
      endcase
      if (1 + run_len(r, c, dr, dc, s) + run_len(r, c, -dr, -dc, s) >= MK) lost = 1;
    end
    if (lost) begin
      mwin = (mturn == 1) ? 2 : 1;
      mover = 1;
    end else if (mcount == MN * MN) begin
      mwin = 3;
      mover = 1;
    end else begin
      mturn = 3 - mturn;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic pulse_reset(input bit which);
    @(negedge clk);
    if (which) reset_b = 1'b1; else reset_a = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_a = 1'b0;
    reset_b = 1'b0;
  endtask

  task automatic rd(input bit which, input int r, input int c, output logic [1:0] v);
    if (which) begin b_rd_row = r[2:0]; b_rd_col = c[2:0]; end
    else       begin a_rd_row = r[1:0]; a_rd_col = c[1:0]; end
    @(negedge clk);
    v = which ? b_rd_sym : a_rd_sym;
  endtask

  // Issues one command. lat counts rising edges with the accept edge as 1, up
  // to the edge after which move_done or reject_err is high; -1 on timeout.
  task automatic issue(input bit which, input int r, input int c, input int s,
                       output int lat, output bit rej);
    int waited = 0;
    lat = -1;
    rej = 0;
    while ((which ? b_ready : a_ready) !== 1'b1 && waited < 60) begin
      @(posedge clk); #1; waited++;
    end
    if (which) begin b_row = r[2:0]; b_col = c[2:0]; b_sym = s[1:0]; b_valid = 1'b1; end
    else       begin a_row = r[1:0]; a_col = c[1:0]; a_sym = s[1:0]; a_valid = 1'b1; end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    // The move in progress must ignore any later change on these inputs.
    a_row = 2'($urandom); a_col = 2'($urandom); a_sym = 2'($urandom);
    b_row = 3'($urandom); b_col = 3'($urandom); b_sym = 2'($urandom);
    for (int i = 2; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (which ? (b_move_done | b_reject_err) : (a_move_done | a_reject_err)) begin
        lat = i;
        rej = which ? b_reject_err : a_reject_err;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [1:0] v;
    int bad = 0;
    int pulses = 0;
    pulse_reset(0);
    tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", a_ready); end
    tests++; if (a_turn !== 2'b01) begin fails++; $display("FAIL reset_turn: got %b want 01", a_turn); end
    tests++; if (a_winner !== 2'b00) begin fails++; $display("FAIL reset_winner: got %b want 00", a_winner); end
    tests++; if (a_game_over !== 1'b0) begin fails++; $display("FAIL reset_game_over: got %b want 0", a_game_over); end
    tests++; if (a_move_count !== 4'd0) begin fails++; $display("FAIL reset_move_count: got %0d want 0", a_move_count); end
    tests++; if ({a_move_done, a_reject_err} !== 2'b00) begin fails++; $display("FAIL reset_pulses: got %b want 00", {a_move_done, a_reject_err}); end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        rd(0, r, c, v);
        if (v !== 2'b00) bad++;
      end
    tests++; if (bad != 0) begin fails++; $display("FAIL reset_board: got %0d nonzero cells want 0", bad); end
    $display("[TB] reset checked");

    // Reset at the same edge as an accept wins: stay in IDLE, no result.
    @(negedge clk);
    a_row = 2'd1; a_col = 2'd1; a_sym = 2'b01; a_valid = 1'b1; reset_a = 1'b1;
    @(posedge clk);
    #1;
    a_valid = 1'b0; reset_a = 1'b0;
    tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL reset_vs_accept_ready: got %b want 1", a_ready); end
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (a_move_done === 1'b1 || a_reject_err === 1'b1) pulses++;
    end
    tests++; if (pulses != 0) begin fails++; $display("FAIL reset_vs_accept_pulses: got %0d want 0", pulses); end
    rd(0, 1, 1, v);
    tests++; if (v !== 2'b00) begin fails++; $display("FAIL reset_vs_accept_cell: got %b want 00", v); end
    $display("[TB] reset vs accept checked");
  endtask

  task automatic test_first_move();
    int lat; bit rej; logic [1:0] v;
    issue(0, 0, 0, 1, lat, rej);
    tests++; if (lat != 19 || rej) begin fails++; $display("FAIL first_move_latency: got lat=%0d rej=%0d want lat=19 rej=0", lat, rej); end
    rd(0, 0, 0, v);
    tests++; if (v !== 2'b01) begin fails++; $display("FAIL first_move_cell: got %b want 01", v); end
    tests++; if (a_turn !== 2'b10) begin fails++; $display("FAIL first_move_turn: got %b want 10", a_turn); end
    tests++; if (a_move_count !== 4'd1) begin fails++; $display("FAIL first_move_count: got %0d want 1", a_move_count); end
    $display("[TB] first move: lat=%0d cell=%b turn=%b count=%0d", lat, v, a_turn, a_move_count);
  endtask

  task automatic test_reject();
    int lat; bit rej; logic [1:0] v;
    int rr[5] = '{0, 3, 1, 1, 1};
    int cc[5] = '{0, 0, 3, 1, 1};
    int ss[5] = '{2, 2, 2, 0, 3};
    for (int i = 0; i < 5; i++) begin
      issue(0, rr[i], cc[i], ss[i], lat, rej);
      tests++; if (lat != 2 || !rej) begin fails++; $display("FAIL reject_%0d: got lat=%0d rej=%0d want lat=2 rej=1", i, lat, rej); end
      tests++; if (a_turn !== 2'b10 || a_move_count !== 4'd1) begin fails++; $display("FAIL reject_state_%0d: got turn=%b count=%0d want turn=10 count=1", i, a_turn, a_move_count); end
      $display("[TB] reject (%0d,%0d) sym=%0d: lat=%0d rej=%0d", rr[i], cc[i], ss[i], lat, rej);
    end
    rd(0, 0, 0, v);
    tests++; if (v !== 2'b01) begin fails++; $display("FAIL reject_cell00: got %b want 01", v); end
    rd(0, 1, 1, v);
    tests++; if (v !== 2'b00) begin fails++; $display("FAIL reject_cell11: got %b want 00", v); end
  endtask

  task automatic test_diag_loss();
    int lat; bit rej;
    pulse_reset(0);
    issue(0, 0, 0, 1, lat, rej);
    issue(0, 1, 1, 1, lat, rej);
    tests++; if (a_game_over !== 1'b0 || a_turn !== 2'b01) begin fails++; $display("FAIL diag_two: got over=%b turn=%b want over=0 turn=01", a_game_over, a_turn); end
    issue(0, 2, 2, 1, lat, rej);
    tests++; if (lat != 19 || rej) begin fails++; $display("FAIL diag_latency: got lat=%0d rej=%0d want lat=19 rej=0", lat, rej); end
    tests++; if (a_winner !== 2'b10 || a_game_over !== 1'b1) begin fails++; $display("FAIL diag_winner: got winner=%b over=%b want winner=10 over=1", a_winner, a_game_over); end
    tests++; if (a_turn !== 2'b01 || a_move_count !== 4'd3) begin fails++; $display("FAIL diag_turn: got turn=%b count=%0d want turn=01 count=3", a_turn, a_move_count); end
    $display("[TB] diagonal loss: winner=%b over=%b turn=%b", a_winner, a_game_over, a_turn);
    issue(0, 0, 1, 2, lat, rej);
    tests++; if (lat != 2 || !rej) begin fails++; $display("FAIL after_over_reject: got lat=%0d rej=%0d want lat=2 rej=1", lat, rej); end
    tests++; if (a_winner !== 2'b10 || a_game_over !== 1'b1 || a_move_count !== 4'd3) begin fails++; $display("FAIL after_over_state: got winner=%b over=%b count=%0d want 10 1 3", a_winner, a_game_over, a_move_count); end
  endtask

  task automatic test_tie();
    int lat; bit rej;
    int early = 0;
    int tr[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    int tc[9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    int ts[9] = '{1, 2, 1, 1, 2, 2, 2, 1, 1};
    pulse_reset(0);
    for (int i = 0; i < 9; i++) begin
      issue(0, tr[i], tc[i], ts[i], lat, rej);
      if (i < 8 && (rej || lat != 19 || a_game_over !== 1'b0)) early++;
    end
    tests++; if (early != 0) begin fails++; $display("FAIL tie_early: got %0d bad moves want 0", early); end
    tests++; if (a_winner !== 2'b11 || a_game_over !== 1'b1) begin fails++; $display("FAIL tie_winner: got winner=%b over=%b want 11 1", a_winner, a_game_over); end
    tests++; if (a_move_count !== 4'd9 || a_turn !== 2'b01) begin fails++; $display("FAIL tie_count: got count=%0d turn=%b want 9 01", a_move_count, a_turn); end
    $display("[TB] tie: winner=%b count=%0d", a_winner, a_move_count);
  endtask

  task automatic test_random_games();
    int lat, r, c, s, bad, post;
    bit rej, mrej;
    logic [1:0] v;
    for (int g = 0; g < 6; g++) begin
      pulse_reset(0);
      model_reset();
      post = 0;
      for (int m = 0; m < 16 && post < 2; m++) begin
        if (mover) post++;
        r = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
        c = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
        s = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 3) : int'($urandom_range(1, 2));
        model_move(r, c, s, mrej);
        issue(0, r, c, s, lat, rej);
        tests++; if (rej != mrej || lat != (mrej ? 2 : 19)) begin fails++; $display("FAIL rand_outcome g%0d m%0d: got lat=%0d rej=%0d want lat=%0d rej=%0d", g, m, lat, rej, mrej ? 2 : 19, mrej); end
        tests++; if (a_turn !== 2'(mturn)) begin fails++; $display("FAIL rand_turn g%0d m%0d: got %b want %0d", g, m, a_turn, mturn); end
        tests++; if (a_winner !== 2'(mwin) || a_game_over !== mover) begin fails++; $display("FAIL rand_winner g%0d m%0d: got winner=%b over=%b want %0d %0d", g, m, a_winner, a_game_over, mwin, mover); end
        tests++; if (a_move_count !== 4'(mcount)) begin fails++; $display("FAIL rand_count g%0d m%0d: got %0d want %0d", g, m, a_move_count, mcount); end
        bad = 0;
        for (int rr = 0; rr < MN; rr++)
          for (int cc = 0; cc < MN; cc++) begin
            rd(0, rr, cc, v);
            if (v !== 2'(mb[rr][cc])) bad++;
          end
        tests++; if (bad != 0) begin fails++; $display("FAIL rand_board g%0d m%0d: got %0d wrong cells want 0", g, m, bad); end
        $display("[TB] game %0d move %0d (%0d,%0d) sym=%0d: rej=%0d lat=%0d winner=%b", g, m, r, c, s, rej, lat, a_winner);
      end
    end
  endtask

  task automatic test_n5k4();
    int lat, bad, pulses;
    bit rej;
    logic [1:0] v;
    pulse_reset(1);
    for (int i = 0; i < 3; i++) begin
      issue(1, 2, i, 2, lat, rej);
      tests++; if (lat != 27 || rej) begin fails++; $display("FAIL n5_move_%0d: got lat=%0d rej=%0d want lat=27 rej=0", i, lat, rej); end
    end
    tests++; if (b_game_over !== 1'b0 || b_winner !== 2'b00 || b_turn !== 2'b10 || b_move_count !== 5'd3) begin
      fails++; $display("FAIL n5_three_run: got over=%b winner=%b turn=%b count=%0d want 0 00 10 3", b_game_over, b_winner, b_turn, b_move_count); end
    issue(1, 2, 3, 2, lat, rej);
    tests++; if (lat != 27 || rej) begin fails++; $display("FAIL n5_loss_latency: got lat=%0d rej=%0d want lat=27 rej=0", lat, rej); end
    tests++; if (b_winner !== 2'b01 || b_game_over !== 1'b1 || b_turn !== 2'b10 || b_move_count !== 5'd4) begin
      fails++; $display("FAIL n5_loss: got winner=%b over=%b turn=%b count=%0d want 01 1 10 4", b_winner, b_game_over, b_turn, b_move_count); end
    $display("[TB] n5k4 four-run loss: lat=%0d winner=%b", lat, b_winner);

    // Reset in the middle of SCAN abandons the move.
    pulse_reset(1);
    issue(1, 0, 0, 1, lat, rej);
    @(negedge clk);
    b_row = 3'd1; b_col = 3'd1; b_sym = 2'b10; b_valid = 1'b1;
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_b = 1'b1;
    @(posedge clk);
    #1;
    reset_b = 1'b0;
    tests++; if (b_ready !== 1'b1 || b_turn !== 2'b01 || b_winner !== 2'b00 || b_game_over !== 1'b0) begin
      fails++; $display("FAIL midscan_state: got ready=%b turn=%b winner=%b over=%b want 1 01 00 0", b_ready, b_turn, b_winner, b_game_over); end
    tests++; if (b_move_count !== 5'd0 || b_move_done !== 1'b0 || b_reject_err !== 1'b0) begin
      fails++; $display("FAIL midscan_counts: got count=%0d done=%b rej=%b want 0 0 0", b_move_count, b_move_done, b_reject_err); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (b_move_done === 1'b1) pulses++;
    end
    tests++; if (pulses != 0) begin fails++; $display("FAIL midscan_done_pulse: got %0d want 0", pulses); end
    bad = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        rd(1, r, c, v);
        if (v !== 2'b00) bad++;
      end
    tests++; if (bad != 0) begin fails++; $display("FAIL midscan_board: got %0d nonzero cells want 0", bad); end
    $display("[TB] n5k4 reset mid-scan checked");
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    a_valid = 1'b0; a_row = '0; a_col = '0; a_sym = '0; a_rd_row = '0; a_rd_col = '0;
    b_valid = 1'b0; b_row = '0; b_col = '0; b_sym = '0; b_rd_row = '0; b_rd_col = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_a = 1'b0; reset_b = 1'b0;

    test_reset();
    test_first_move();
    test_reject();
    test_diag_loss();
    test_tie();
    test_random_games();
    test_n5k4();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
